// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage pipeline.
// Resolves operand forwarding, evaluates the ALU operation, runs an iterative
// unsigned multiply/divide unit (one result bit per cycle) with HI/LO, and
// holds the EX/MEM pipeline register.
// Handshake: stall_out is combinational; while it is high the upstream stages
// hold, and this stage writes a bubble.
// Optional feature: define EX_OVERFLOW_EXC_EN to flag signed ADD/SUB overflow
// on exc_ovf and suppress the register write for that instruction.
module ex_stage #(
  parameter int unsigned MDU_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        in_valid,
  input  logic        flush,
  input  logic [3:0]  alu_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [31:0] imm,
  input  logic [4:0]  shamt,
  input  logic        alu_src,
  input  logic [1:0]  fwd_a,
  input  logic [1:0]  fwd_b,
  input  logic [31:0] wb_data,
  input  logic [4:0]  in_write_reg,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic        in_reg_write,
  input  logic        in_lu_op,
  input  logic [1:0]  in_mem_to_reg,
  input  logic [31:0] in_pc_plus4,
  input  logic [31:0] in_lu_data,
  output logic        stall_out,
  output logic [31:0] ex_alu_s,
  output logic [31:0] ex_mem_wdata,
  output logic [4:0]  ex_write_reg,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_reg_write,
  output logic        ex_lu_op,
  output logic [1:0]  ex_mem_to_reg,
  output logic [31:0] ex_pc_plus4,
  output logic [31:0] ex_lu_data,
  output logic        exc_ovf
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NOR   = 4'd5;
  localparam logic [3:0] OP_SLL   = 4'd6;
  localparam logic [3:0] OP_SRL   = 4'd7;
  localparam logic [3:0] OP_SRA   = 4'd8;
  localparam logic [3:0] OP_SLT   = 4'd9;
  localparam logic [3:0] OP_SLTU  = 4'd10;
  localparam logic [3:0] OP_MFHI  = 4'd11;
  localparam logic [3:0] OP_MFLO  = 4'd12;
  localparam logic [3:0] OP_MULTU = 4'd13;
  localparam logic [3:0] OP_DIVU  = 4'd14;
  localparam logic [3:0] OP_PASSB = 4'd15;

  localparam logic [5:0] CNT_LAST = 6'(MDU_CYCLES - 1);

  typedef enum logic {MDU_IDLE, MDU_BUSY} mdu_state_e;

  // MDU state (mdu_state_q is the observable FSM state)
  mdu_state_e  mdu_state_q, mdu_state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        mdu_div_q, mdu_div_d;
  logic [31:0] acc_hi_q, acc_hi_d;
  logic [31:0] acc_lo_q, acc_lo_d;
  logic [31:0] opnd_q, opnd_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // EX/MEM pipeline register
  logic [31:0] ex_alu_s_q, ex_alu_s_d;
  logic [31:0] ex_mem_wdata_q, ex_mem_wdata_d;
  logic [4:0]  ex_write_reg_q, ex_write_reg_d;
  logic        ex_mem_read_q, ex_mem_read_d;
  logic        ex_mem_write_q, ex_mem_write_d;
  logic        ex_reg_write_q, ex_reg_write_d;
  logic        ex_lu_op_q, ex_lu_op_d;
  logic [1:0]  ex_mem_to_reg_q, ex_mem_to_reg_d;
  logic [31:0] ex_pc_plus4_q, ex_pc_plus4_d;
  logic [31:0] ex_lu_data_q, ex_lu_data_d;

  logic [31:0] fwd_a_val, fwd_b_val, op_a, op_b;
  logic [31:0] add_res, sub_res, alu_res;
  logic        is_mdu_op, is_hilo_user, bubble, mdu_start;
  logic [32:0] mul_sum, div_shift, div_trial;
  logic        div_ok;
  logic [31:0] step_hi, step_lo;
  logic        unused_div_msb;

  // Operand forwarding; code 11 is reserved and behaves like 00
  always_comb begin
    fwd_a_val = rs_data;
    fwd_b_val = rt_data;
    case (fwd_a)
      2'b01:   fwd_a_val = ex_alu_s_q;
      2'b10:   fwd_a_val = wb_data;
      default: fwd_a_val = rs_data;
    endcase
    case (fwd_b)
      2'b01:   fwd_b_val = ex_alu_s_q;
      2'b10:   fwd_b_val = wb_data;
      default: fwd_b_val = rt_data;
    endcase
  end

  assign op_a    = fwd_a_val;
  assign op_b    = alu_src ? imm : fwd_b_val;
  assign add_res = op_a + op_b;
  assign sub_res = op_a - op_b;

  assign is_mdu_op    = (alu_op == OP_MULTU) || (alu_op == OP_DIVU);
  assign is_hilo_user = is_mdu_op || (alu_op == OP_MFHI) || (alu_op == OP_MFLO);
  assign stall_out    = (mdu_state_q == MDU_BUSY) && in_valid && is_hilo_user;
  assign bubble       = !in_valid || flush || stall_out;
  assign mdu_start    = !bubble && is_mdu_op && (mdu_state_q == MDU_IDLE);

  // ALU result selection; MULTU/DIVU produce 0 here
  always_comb begin
    alu_res = 32'd0;
    case (alu_op)
      OP_ADD:   alu_res = add_res;
      OP_SUB:   alu_res = sub_res;
      OP_AND:   alu_res = op_a & op_b;
      OP_OR:    alu_res = op_a | op_b;
      OP_XOR:   alu_res = op_a ^ op_b;
      OP_NOR:   alu_res = ~(op_a | op_b);
      OP_SLL:   alu_res = op_b << shamt;
      OP_SRL:   alu_res = op_b >> shamt;
      OP_SRA:   alu_res = $unsigned($signed(op_b) >>> shamt);
      OP_SLT:   alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
      OP_SLTU:  alu_res = {31'd0, op_a < op_b};
      OP_MFHI:  alu_res = hi_q;
      OP_MFLO:  alu_res = lo_q;
      OP_PASSB: alu_res = op_b;
      default:  alu_res = 32'd0;
    endcase
  end

`ifdef EX_OVERFLOW_EXC_EN
  logic ovf;
  logic exc_ovf_q, exc_ovf_d;
  assign ovf = ((alu_op == OP_ADD) && (op_a[31] == op_b[31]) && (add_res[31] != op_a[31])) ||
               ((alu_op == OP_SUB) && (op_a[31] != op_b[31]) && (sub_res[31] != op_a[31]));
  assign exc_ovf = exc_ovf_q;
`else
  assign exc_ovf = 1'b0;
`endif

  // Next EX/MEM register contents; bubbles clear every field
  always_comb begin
    ex_alu_s_d      = 32'd0;
    ex_mem_wdata_d  = 32'd0;
    ex_write_reg_d  = 5'd0;
    ex_mem_read_d   = 1'b0;
    ex_mem_write_d  = 1'b0;
    ex_reg_write_d  = 1'b0;
    ex_lu_op_d      = 1'b0;
    ex_mem_to_reg_d = 2'd0;
    ex_pc_plus4_d   = 32'd0;
    ex_lu_data_d    = 32'd0;
`ifdef EX_OVERFLOW_EXC_EN
    exc_ovf_d       = 1'b0;
`endif
    if (!bubble) begin
      ex_alu_s_d      = alu_res;
      ex_mem_wdata_d  = fwd_b_val;
      ex_write_reg_d  = in_write_reg;
      ex_mem_read_d   = in_mem_read;
      ex_mem_write_d  = in_mem_write;
      ex_reg_write_d  = in_reg_write && !is_mdu_op;
      ex_lu_op_d      = in_lu_op;
      ex_mem_to_reg_d = in_mem_to_reg;
      ex_pc_plus4_d   = in_pc_plus4;
      ex_lu_data_d    = in_lu_data;
`ifdef EX_OVERFLOW_EXC_EN
      if (ovf) begin
        exc_ovf_d      = 1'b1;
        ex_reg_write_d = 1'b0;
      end
`endif
    end
  end

  // One MDU iteration: shift-add multiply or restoring divide step
  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : 33'd0);
    div_shift = {acc_hi_q, acc_lo_q[31]};
    div_trial = div_shift - {1'b0, opnd_q};
    div_ok    = div_shift >= {1'b0, opnd_q};
    if (mdu_div_q) begin
      step_hi = div_ok ? div_trial[31:0] : div_shift[31:0];
      step_lo = {acc_lo_q[30:0], div_ok};
    end else begin
      step_hi = mul_sum[32:1];
      step_lo = {mul_sum[0], acc_lo_q[31:1]};
    end
  end

  // A successful trial subtraction always leaves a value below the divisor
  assign unused_div_msb = div_trial[32];

  // MDU next-state: latch operands on start, iterate, commit HI/LO at the end
  always_comb begin
    mdu_state_d = mdu_state_q;
    cnt_d       = cnt_q;
    mdu_div_d   = mdu_div_q;
    acc_hi_d    = acc_hi_q;
    acc_lo_d    = acc_lo_q;
    opnd_d      = opnd_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    case (mdu_state_q)
      MDU_IDLE: begin
        if (mdu_start) begin
          mdu_state_d = MDU_BUSY;
          cnt_d       = 6'd0;
          mdu_div_d   = (alu_op == OP_DIVU);
          acc_hi_d    = 32'd0;
          acc_lo_d    = op_a;
          opnd_d      = op_b;
        end
      end
      default: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt_q + 6'd1;
        if (cnt_q == CNT_LAST) begin
          mdu_state_d = MDU_IDLE;
          cnt_d       = 6'd0;
          hi_d        = step_hi;
          lo_d        = step_lo;
        end
      end
    endcase
  end

  // MDU FSM and HI/LO registers
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      mdu_state_q <= MDU_IDLE;
      cnt_q       <= 6'd0;
      mdu_div_q   <= 1'b0;
      acc_hi_q    <= 32'd0;
      acc_lo_q    <= 32'd0;
      opnd_q      <= 32'd0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
    end else begin
      mdu_state_q <= mdu_state_d;
      cnt_q       <= cnt_d;
      mdu_div_q   <= mdu_div_d;
      acc_hi_q    <= acc_hi_d;
      acc_lo_q    <= acc_lo_d;
      opnd_q      <= opnd_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  // EX/MEM pipeline register
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      ex_alu_s_q      <= 32'd0;
      ex_mem_wdata_q  <= 32'd0;
      ex_write_reg_q  <= 5'd0;
      ex_mem_read_q   <= 1'b0;
      ex_mem_write_q  <= 1'b0;
      ex_reg_write_q  <= 1'b0;
      ex_lu_op_q      <= 1'b0;
      ex_mem_to_reg_q <= 2'd0;
      ex_pc_plus4_q   <= 32'd0;
      ex_lu_data_q    <= 32'd0;
`ifdef EX_OVERFLOW_EXC_EN
      exc_ovf_q       <= 1'b0;
`endif
    end else begin
      ex_alu_s_q      <= ex_alu_s_d;
      ex_mem_wdata_q  <= ex_mem_wdata_d;
      ex_write_reg_q  <= ex_write_reg_d;
      ex_mem_read_q   <= ex_mem_read_d;
      ex_mem_write_q  <= ex_mem_write_d;
      ex_reg_write_q  <= ex_reg_write_d;
      ex_lu_op_q      <= ex_lu_op_d;
      ex_mem_to_reg_q <= ex_mem_to_reg_d;
      ex_pc_plus4_q   <= ex_pc_plus4_d;
      ex_lu_data_q    <= ex_lu_data_d;
`ifdef EX_OVERFLOW_EXC_EN
      exc_ovf_q       <= exc_ovf_d;
`endif
    end
  end

  assign ex_alu_s      = ex_alu_s_q;
  assign ex_mem_wdata  = ex_mem_wdata_q;
  assign ex_write_reg  = ex_write_reg_q;
  assign ex_mem_read   = ex_mem_read_q;
  assign ex_mem_write  = ex_mem_write_q;
  assign ex_reg_write  = ex_reg_write_q;
  assign ex_lu_op      = ex_lu_op_q;
  assign ex_mem_to_reg = ex_mem_to_reg_q;
  assign ex_pc_plus4   = ex_pc_plus4_q;
  assign ex_lu_data    = ex_lu_data_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: forwarding, ALU ops, MULTU/DIVU with stalls,
// flush behaviour and asynchronous reset in the middle of an MDU operation.
module tb_ex_stage;

`ifdef EX_OVERFLOW_EXC_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_b;
  logic        in_valid, flush, alu_src;
  logic [3:0]  alu_op;
  logic [31:0] rs_data, rt_data, imm, wb_data, in_pc_plus4, in_lu_data;
  logic [4:0]  shamt, in_write_reg;
  logic [1:0]  fwd_a, fwd_b, in_mem_to_reg;
  logic        in_mem_read, in_mem_write, in_reg_write, in_lu_op;
  logic        stall_out, ex_mem_read, ex_mem_write, ex_reg_write, ex_lu_op, exc_ovf;
  logic [31:0] ex_alu_s, ex_mem_wdata, ex_pc_plus4, ex_lu_data;
  logic [4:0]  ex_write_reg;
  logic [1:0]  ex_mem_to_reg;

  int n_checks = 0;
  int n_pass   = 0;
  int n_stall;

  ex_stage #(.MDU_CYCLES(32)) dut (
    .clk(clk), .reset_b(reset_b), .in_valid(in_valid), .flush(flush),
    .alu_op(alu_op), .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
    .shamt(shamt), .alu_src(alu_src), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .wb_data(wb_data), .in_write_reg(in_write_reg), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .in_reg_write(in_reg_write), .in_lu_op(in_lu_op),
    .in_mem_to_reg(in_mem_to_reg), .in_pc_plus4(in_pc_plus4), .in_lu_data(in_lu_data),
    .stall_out(stall_out), .ex_alu_s(ex_alu_s), .ex_mem_wdata(ex_mem_wdata),
    .ex_write_reg(ex_write_reg), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_lu_op(ex_lu_op), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_pc_plus4(ex_pc_plus4), .ex_lu_data(ex_lu_data), .exc_ovf(exc_ovf)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // advance one clock and settle past the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; flush = 1'b0; alu_op = 4'd0; rs_data = 32'd0; rt_data = 32'd0;
    imm = 32'd0; shamt = 5'd0; alu_src = 1'b0; fwd_a = 2'd0; fwd_b = 2'd0;
    wb_data = 32'd0; in_write_reg = 5'd0; in_mem_read = 1'b0; in_mem_write = 1'b0;
    in_reg_write = 1'b0; in_lu_op = 1'b0; in_mem_to_reg = 2'd0;
    in_pc_plus4 = 32'd0; in_lu_data = 32'd0;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    idle();
    in_valid = 1'b1; alu_op = op; rs_data = a; rt_data = b;
    in_reg_write = 1'b1; in_write_reg = 5'd3;
  endtask

  // hold the current inputs until stall_out drops, bounded
  task automatic wait_stall(output int n);
    n = 0;
    #1;
    while (stall_out === 1'b1 && n < 200) begin
      step();
      n++;
      if (n == 1) check("stall_bubble_rw", {31'd0, ex_reg_write}, 32'd0);
    end
    if (n >= 200) check("stall_timeout", 32'd1, 32'd0);
  endtask

  task automatic alu_vec(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    drive(op, a, b);
    shamt = 5'd4;
    step();
    check(tag, ex_alu_s, exp);
  endtask

  initial begin
    idle();
    reset_b = 1'b0;
    #12;
    check("rst_alu_s", ex_alu_s, 32'd0);
    check("rst_reg_write", {31'd0, ex_reg_write}, 32'd0);
    check("rst_stall", {31'd0, stall_out}, 32'd0);
    check("rst_exc_ovf", {31'd0, exc_ovf}, 32'd0);
    @(posedge clk); #1;
    reset_b = 1'b1;

    // ADD overflow boundary
    drive(4'd0, 32'h7FFF_FFFF, 32'd0);
    imm = 32'd1; alu_src = 1'b1;
    step();
    check("add_wrap", ex_alu_s, 32'h8000_0000);
    check("add_ovf_rw", {31'd0, ex_reg_write}, OVF_EN ? 32'd0 : 32'd1);
    check("add_ovf_flag", {31'd0, exc_ovf}, {31'd0, OVF_EN});

    // forwarding
    drive(4'd0, 32'h10, 32'd0);
    step();
    check("fwd_seed", ex_alu_s, 32'h10);
    check("no_ovf_flag", {31'd0, exc_ovf}, 32'd0);
    drive(4'd1, 32'hDEAD_BEEF, 32'h5);
    fwd_a = 2'b01;
    step();
    check("fwd_a_own", ex_alu_s, 32'h0000_000B);
    drive(4'd1, 32'h20, 32'h1234_5678);
    fwd_b = 2'b10; wb_data = 32'd3;
    step();
    check("fwd_b_wb", ex_alu_s, 32'h1D);
    check("fwd_b_wdata", ex_mem_wdata, 32'd3);
    drive(4'd1, 32'h20, 32'h4);
    fwd_b = 2'b11; wb_data = 32'd9;
    step();
    check("fwd_b_rsvd", ex_alu_s, 32'h1C);

    // ALU op table (shamt = 4)
    alu_vec("and",  4'd2,  32'hF0F0_00FF, 32'h8000_0F0F, 32'h8000_000F);
    alu_vec("or",   4'd3,  32'hF0F0_00FF, 32'h8000_0F0F, 32'hF0F0_0FFF);
    alu_vec("xor",  4'd4,  32'hF0F0_00FF, 32'h8000_0F0F, 32'h70F0_0FF0);
    alu_vec("nor",  4'd5,  32'hF0F0_00FF, 32'h8000_0F0F, 32'h0F0F_F000);
    alu_vec("sll",  4'd6,  32'd0,         32'h8000_0F0F, 32'h0000_F0F0);
    alu_vec("srl",  4'd7,  32'd0,         32'h8000_0F0F, 32'h0800_00F0);
    alu_vec("sra",  4'd8,  32'd0,         32'h8000_0F0F, 32'hF800_00F0);
    alu_vec("slt0", 4'd9,  32'hF0F0_00FF, 32'h8000_0F0F, 32'd0);
    alu_vec("slt1", 4'd9,  32'hFFFF_FFFF, 32'd1,         32'd1);
    alu_vec("sltu0",4'd10, 32'hFFFF_FFFF, 32'd1,         32'd0);
    alu_vec("sltu1",4'd10, 32'd1,         32'd2,         32'd1);
    alu_vec("passb",4'd15, 32'd7,         32'h8000_0F0F, 32'h8000_0F0F);

    // control/side fields pass through, then a bubble clears them
    drive(4'd0, 32'h1000, 32'h0000_DEAD);
    imm = 32'd4; alu_src = 1'b1; in_mem_read = 1'b1; in_mem_to_reg = 2'b01;
    in_pc_plus4 = 32'h40; in_lu_op = 1'b1; in_lu_data = 32'h1234_0000; in_write_reg = 5'd9;
    step();
    check("pt_alu", ex_alu_s, 32'h1004);
    check("pt_wdata", ex_mem_wdata, 32'h0000_DEAD);
    check("pt_wreg", {27'd0, ex_write_reg}, 32'd9);
    check("pt_mread", {31'd0, ex_mem_read}, 32'd1);
    check("pt_m2r", {30'd0, ex_mem_to_reg}, 32'd1);
    check("pt_pc4", ex_pc_plus4, 32'h40);
    check("pt_lu", {31'd0, ex_lu_op}, 32'd1);
    check("pt_ludata", ex_lu_data, 32'h1234_0000);
    idle();
    step();
    check("bub_mread", {31'd0, ex_mem_read}, 32'd0);
    check("bub_rw", {31'd0, ex_reg_write}, 32'd0);
    check("bub_pc4", ex_pc_plus4, 32'd0);

    // MULTU max*max then dependent MFHI
    drive(4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step();
    check("mul_alu_s", ex_alu_s, 32'd0);
    check("mul_rw", {31'd0, ex_reg_write}, 32'd0);
    drive(4'd11, 32'd0, 32'd0);
    wait_stall(n_stall);
    check("mul_stall_cycles", n_stall, 32'd32);
    step();
    check("mfhi_mul", ex_alu_s, 32'hFFFF_FFFE);
    check("mfhi_rw", {31'd0, ex_reg_write}, 32'd1);
    drive(4'd12, 32'd0, 32'd0);
    #1;
    check("mflo_nostall", {31'd0, stall_out}, 32'd0);
    step();
    check("mflo_mul", ex_alu_s, 32'h0000_0001);

    // DIVU 100/7, with a flushed MFLO during the stall
    drive(4'd14, 32'd100, 32'd7);
    step();
    drive(4'd12, 32'd0, 32'd0);
    flush = 1'b1;
    #1;
    check("flush_stall", {31'd0, stall_out}, 32'd1);
    step();
    check("flush_stall_rw", {31'd0, ex_reg_write}, 32'd0);
    flush = 1'b0;
    wait_stall(n_stall);
    step();
    check("div_lo", ex_alu_s, 32'd14);
    drive(4'd11, 32'd0, 32'd0);
    step();
    check("div_hi", ex_alu_s, 32'd2);

    // DIVU 5/0
    drive(4'd14, 32'd5, 32'd0);
    step();
    drive(4'd12, 32'd0, 32'd0);
    wait_stall(n_stall);
    step();
    check("div0_lo", ex_alu_s, 32'hFFFF_FFFF);
    drive(4'd11, 32'd0, 32'd0);
    step();
    check("div0_hi", ex_alu_s, 32'd5);

    // flushed MULTU never starts
    drive(4'd13, 32'd3, 32'd4);
    flush = 1'b1;
    step();
    check("fmul_rw", {31'd0, ex_reg_write}, 32'd0);
    drive(4'd12, 32'd0, 32'd0);
    #1;
    check("fmul_nostall", {31'd0, stall_out}, 32'd0);
    step();
    check("fmul_old_lo", ex_alu_s, 32'hFFFF_FFFF);

    // independent ADD proceeds while MDU is busy
    drive(4'd13, 32'd3, 32'd4);
    step();
    drive(4'd0, 32'd2, 32'd3);
    #1;
    check("busy_add_nostall", {31'd0, stall_out}, 32'd0);
    step();
    check("busy_add", ex_alu_s, 32'd5);
    drive(4'd12, 32'd0, 32'd0);
    wait_stall(n_stall);
    step();
    check("mul34_lo", ex_alu_s, 32'd12);

    // reset in the middle of a busy MULTU
    drive(4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step();
    drive(4'd0, 32'd2, 32'd3);
    step();
    idle();
    step();
    step();
    drive(4'd0, 32'd6, 32'd1);
    step();
    check("pre_rst_alu", ex_alu_s, 32'd7);
    idle();
    reset_b = 1'b0;
    #1;
    check("midrst_alu", ex_alu_s, 32'd0);
    check("midrst_rw", {31'd0, ex_reg_write}, 32'd0);
    @(posedge clk); #1;
    reset_b = 1'b1;
    drive(4'd11, 32'd0, 32'd0);
    #1;
    check("postrst_nostall", {31'd0, stall_out}, 32'd0);
    step();
    check("postrst_hi", ex_alu_s, 32'd0);
    drive(4'd12, 32'd0, 32'd0);
    step();
    check("postrst_lo", ex_alu_s, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage pipeline; sits between the ID/EX register and the memory stage.
- Resolves operand forwarding, performs the ALU operation, and runs an iterative unsigned multiply/divide unit with HI/LO registers.
- Registers every field the memory stage consumes (ALU result, store data, destination register, control) as the EX/MEM pipeline register.
- Asserts a stall to upstream while a HI/LO consumer must wait for the multiply/divide unit.

Parameters:
- MDU_CYCLES, 32, iterations per MULTU/DIVU; legal range 1..32; one result bit per cycle.

Ports:
- clk  in  1  pipeline clock
- reset_b  in  1  asynchronous active-low reset
- in_valid  in  1  ID/EX holds a real instruction
- flush  in  1  squash the instruction in EX this cycle
- alu_op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLL, 7 SRL, 8 SRA, 9 SLT, 10 SLTU, 11 MFHI, 12 MFLO, 13 MULTU, 14 DIVU, 15 PASSB
- rs_data, rt_data  in  32  register-file operands
- imm  in  32  extended immediate
- shamt  in  5  shift amount
- alu_src  in  1  B operand = imm (1) or forwarded rt (0)
- fwd_a, fwd_b  in  2  00 register value, 01 ex_alu_s (own output), 10 wb_data, 11 reserved (treated as 00)
- wb_data  in  32  write-back data from MEM/WB
- in_write_reg  in  5
- in_mem_read, in_mem_write, in_reg_write, in_lu_op  in  1
- in_mem_to_reg  in  2
- in_pc_plus4, in_lu_data  in  32
- stall_out  out  1  hold PC/IF/ID/ID-EX this cycle
- ex_alu_s  out  32  registered ALU result
- ex_mem_wdata  out  32  registered forwarded rt
- ex_write_reg  out  5
- ex_mem_read, ex_mem_write, ex_reg_write, ex_lu_op  out  1
- ex_mem_to_reg  out  2
- ex_pc_plus4, ex_lu_data  out  32
- exc_ovf  out  1  registered overflow flag (optional feature only; else tied 0)

Behaviour:
- Reset (asynchronous, reset_b=0): all ex_* outputs 0, HI=LO=0, MDU idle, counter 0, exc_ovf 0.
- Operand A = forwarded rs. Operand B = imm if alu_src, else forwarded rt. ex_mem_wdata always uses forwarded rt.
- Latency: one cycle; outputs update on the rising clk edge after the inputs are presented.
- Shifts use the shamt input (variable shifts get shamt from ID). SLT is signed, SLTU unsigned; result is 0 or 1.
- ADD and SUB wrap modulo 2^32. PASSB returns B.
- MFHI and MFLO return HI and LO.
- MULTU and DIVU write ALU_S=0 and force ex_reg_write=0.
- Bubble: ex_reg_write, ex_mem_read and ex_mem_write are 0; all other ex_* fields are don't-care but held at 0.
- A bubble is written when in_valid=0, flush=1, or stall_out=1.
- MDU states: IDLE, BUSY. Counter runs 0..MDU_CYCLES-1.
  - IDLE->BUSY: a valid, unflushed, unstalled MULTU/DIVU; operands are latched at that edge.
  - BUSY->IDLE: after MDU_CYCLES edges; HI/LO are written at the final edge.
- MULTU: shift-add; {HI,LO} = 64-bit product.
- DIVU: restoring division; LO = quotient, HI = remainder.
- Divide by zero: no trap; LO=0xFFFFFFFF, HI=dividend (the natural restoring result).
- stall_out=1 (combinational) when MDU is BUSY and in_valid=1 and alu_op is MFHI, MFLO, MULTU or DIVU.
- stall_out is never asserted for other ops; independent instructions proceed while the MDU is BUSY.
- On the edge where BUSY->IDLE, stall_out drops combinationally in the next cycle. A waiting MFHI then reads the new HI.
- Flush: never aborts an in-flight MDU operation. A MULTU/DIVU with flush=1 does not start.
- Flush and stall together: a bubble is written; the stall still holds upstream.
- Reset mid-operation aborts the MDU, and HI/LO return to 0.

Optional Feature:
- Macro: EX_OVERFLOW_EXC_EN.
- Defined: signed overflow on ADD/SUB registers exc_ovf=1 for that instruction and forces ex_reg_write=0. ALU_S still holds the wrapped sum.
- Not defined: exc_ovf is constant 0 and overflow is ignored.

Test Plan:
- ADD, rs=0x7FFFFFFF, imm=1, alu_src=1 -> next cycle ex_alu_s=0x80000000. With the macro defined: exc_ovf=1, ex_reg_write=0.
- Back-to-back dependency: fwd_a=01 with prior result 0x10 and rt=0x5, SUB -> ex_alu_s=0x0000000B. Repeat with fwd_b=10, wb_data=3 -> value 3 used as B.
- MULTU 0xFFFFFFFF*0xFFFFFFFF then immediate MFHI -> stall_out=1 for MDU_CYCLES cycles with bubbles emitted; then ex_alu_s=0xFFFFFFFE. A following MFLO gives 0x00000001.
- DIVU 100/7 -> LO=14, HI=2. DIVU 5/0 -> LO=0xFFFFFFFF, HI=5.
- MULTU issued with flush=1 -> MDU stays IDLE; following MFLO returns old LO with no stall. ADD issued while BUSY -> no stall, result next cycle.
- Assert reset_b=0 mid-BUSY -> all outputs 0 immediately, stall_out=0 after release, MFHI returns 0.
